alu_seq: RTL and testbench

//  Parametrised successor to the datapath ALU. Computes add/sub/xor/and/or/compare of acc and ibus under

---
 rtl/alu_seq_if.sv | 16 +
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand, control-word and result bundle between the microsequencer/accumulator side and alu_seq.
interface alu_seq_if #(
    parameter int SZ = 27,
    parameter int W  = 8
);
  logic [SZ-1:0] CS_bus;
  logic [W-1:0]  acc;
  logic [W-1:0]  ibus;
  logic [W-1:0]  obus;
  logic [3:0]    flags;
  logic          busy;
  logic          done;

  modport master(output CS_bus, acc, ibus, input obus, flags, busy, done);
  modport slave (input CS_bus, acc, ibus, output obus, flags, busy, done);
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with Z/ZH result registers and a {V,N,C,Z} status register.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier (busy/done, ZH).
module alu_seq #(
    parameter int SZ     = 27,
    parameter int W      = 8,
    parameter int ADD_B  = 0,
    parameter int CMP_B  = 1,
    parameter int SUB_B  = 2,
    parameter int XOR_B  = 3,
    parameter int AND_B  = 4,
    parameter int OR_B   = 5,
    parameter int MUL_B  = 6,
    parameter int ZH_OUT = 24,
    parameter int Z_OUT  = 25
) (
  input logic      CLK,
  input logic      RST,
  alu_seq_if.slave bus
);

  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_CMP, OP_MUL} op_t;

  op_t          op;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] res;
  logic         res_c;
  logic         res_v;
  logic [3:0]   alu_flags;
  logic [W-1:0] z_reg;
  logic [3:0]   flags_reg;
  logic [W-1:0] zh_val;
  logic         alu_idle;
  logic         mul_wr;
  logic [W-1:0] mul_lo;
  logic [W-1:0] mul_hi;

  always_comb begin
    op = OP_NONE;
    if (bus.CS_bus[ADD_B])      op = OP_ADD;
    else if (bus.CS_bus[SUB_B]) op = OP_SUB;
    else if (bus.CS_bus[XOR_B]) op = OP_XOR;
    else if (bus.CS_bus[AND_B]) op = OP_AND;
    else if (bus.CS_bus[OR_B])  op = OP_OR;
    else if (bus.CS_bus[CMP_B]) op = OP_CMP;
`ifdef ALU_SEQ_MUL_EN
    else if (bus.CS_bus[MUL_B]) op = OP_MUL;
`endif
  end

  always_comb begin
    sum   = {1'b0, bus.acc} + {1'b0, bus.ibus};
    diff  = {1'b0, bus.acc} - {1'b0, bus.ibus};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum[W-1:0];
        res_c = sum[W];
        res_v = (bus.acc[W-1] == bus.ibus[W-1]) && (sum[W-1] != bus.acc[W-1]);
      end
      OP_SUB, OP_CMP: begin
        // diff[W] is the borrow, set exactly when acc < ibus unsigned
        res   = diff[W-1:0];
        res_c = diff[W];
        res_v = (bus.acc[W-1] != bus.ibus[W-1]) && (diff[W-1] != bus.acc[W-1]);
      end
      OP_XOR:  res = bus.acc ^ bus.ibus;
      OP_AND:  res = bus.acc & bus.ibus;
      OP_OR:   res = bus.acc | bus.ibus;
      default: res = '0;
    endcase
    alu_flags = {res_v, res[W-1], res_c, (res == '0)};
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [2*W-1:0] mcand_reg, mcand_next;
  logic [2*W-1:0] prod_reg, prod_next;
  logic [W-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [W-1:0]   zh_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      prod_reg   <= prod_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    prod_next   = prod_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    mul_wr      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (op == OP_MUL) begin
          state_next  = RUN;
          mcand_next  = {{W{1'b0}}, bus.acc};
          mplier_next = bus.ibus;
          prod_next   = '0;
          cnt_next    = '0;
        end
      end
      RUN: begin
        prod_next   = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        // The last step's product is committed on the same edge that enters DONE,
        // so Z/ZH already hold the result while done is high.
        if (cnt_reg == CW'(W - 1)) begin
          state_next = DONE;
          mul_wr     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mul_lo   = prod_next[W-1:0];
  assign mul_hi   = prod_next[2*W-1:W];
  assign alu_idle = (state_reg != RUN);
  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign zh_val   = zh_reg;

  always_ff @(posedge CLK) begin
    if (RST)         zh_reg <= '0;
    else if (mul_wr) zh_reg <= mul_hi;
  end
`else
  logic unused_mul;

  assign unused_mul = bus.CS_bus[MUL_B];
  assign mul_wr     = 1'b0;
  assign mul_lo     = '0;
  assign mul_hi     = '0;
  assign alu_idle   = 1'b1;
  assign bus.busy   = 1'b0;
  assign bus.done   = 1'b0;
  assign zh_val     = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      z_reg     <= '0;
      flags_reg <= '0;
    end else if (mul_wr) begin
      z_reg     <= mul_lo;
      flags_reg <= {1'b0, mul_lo[W-1], (mul_hi != '0), (mul_lo == '0)};
    end else if (alu_idle && op != OP_NONE && op != OP_MUL) begin
      if (op != OP_CMP) z_reg <= res;
      flags_reg <= alu_flags;
    end
  end

  assign bus.flags = flags_reg;
  assign bus.obus  = bus.CS_bus[Z_OUT]  ? z_reg :
                     bus.CS_bus[ZH_OUT] ? zh_val : {W{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table through an expected-result queue, then multiplier sequences
// (or the MUL-ignored check when ALU_SEQ_MUL_EN is not defined).
module tb_alu_seq;
  localparam int SZ = 27;
  localparam int W  = 8;

  localparam logic [SZ-1:0] C_ADD = 27'h1;
  localparam logic [SZ-1:0] C_CMP = 27'h2;
  localparam logic [SZ-1:0] C_SUB = 27'h4;
  localparam logic [SZ-1:0] C_XOR = 27'h8;
  localparam logic [SZ-1:0] C_AND = 27'h10;
  localparam logic [SZ-1:0] C_OR  = 27'h20;
  localparam logic [SZ-1:0] C_MUL = 27'h40;
  localparam logic [SZ-1:0] C_ZH  = 27'h1 << 24;
  localparam logic [SZ-1:0] C_Z   = 27'h1 << 25;

  typedef struct {
    logic [SZ-1:0] cs;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  z;
    logic [3:0]    fl;
  } vec_t;

  typedef struct {
    logic [W-1:0] z;
    logic [3:0]   fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;
  vec_t vecs[17];
  exp_t sb[$];

  alu_seq_if #(.SZ(SZ), .W(W)) bus ();

  alu_seq #(.SZ(SZ), .W(W)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic read_z(output logic [W-1:0] v);
    bus.CS_bus = C_Z;
    #1;
    v = bus.obus;
  endtask

  task automatic read_zh(output logic [W-1:0] v);
    bus.CS_bus = C_ZH;
    #1;
    v = bus.obus;
  endtask

  initial begin
    logic [W-1:0] rd;
    exp_t         e;
    int           n;
    int           dn;

    vecs[0]  = '{C_ADD,                 8'hF0, 8'h20, 8'h10, 4'h2};
    vecs[1]  = '{C_ADD,                 8'h7F, 8'h01, 8'h80, 4'hC};
    vecs[2]  = '{C_ADD,                 8'hF0, 8'h20, 8'h10, 4'h2};
    vecs[3]  = '{C_CMP,                 8'h05, 8'h05, 8'h10, 4'h1};
    vecs[4]  = '{C_CMP,                 8'h03, 8'h05, 8'h10, 4'h6};
    vecs[5]  = '{C_ADD | C_XOR,         8'h0F, 8'hF0, 8'hFF, 4'h4};
    vecs[6]  = '{27'h0,                 8'h12, 8'h34, 8'hFF, 4'h4};
    vecs[7]  = '{C_SUB,                 8'h05, 8'h05, 8'h00, 4'h1};
    vecs[8]  = '{C_SUB,                 8'h80, 8'h01, 8'h7F, 4'h8};
    vecs[9]  = '{C_XOR,                 8'hAA, 8'hFF, 8'h55, 4'h0};
    vecs[10] = '{C_AND,                 8'hF0, 8'h0F, 8'h00, 4'h1};
    vecs[11] = '{C_OR,                  8'h80, 8'h01, 8'h81, 4'h4};
    vecs[12] = '{C_SUB | C_AND,         8'h00, 8'h01, 8'hFF, 4'h6};
    vecs[13] = '{C_AND | C_OR | C_CMP,  8'hF0, 8'h3C, 8'h30, 4'h0};
    vecs[14] = '{C_OR | C_CMP,          8'h00, 8'h00, 8'h00, 4'h1};
    vecs[15] = '{C_CMP | C_MUL,         8'h01, 8'h02, 8'h00, 4'h6};
    vecs[16] = '{C_ADD,                 8'h80, 8'h80, 8'h00, 4'hB};

    bus.CS_bus = '0;
    bus.acc    = '0;
    bus.ibus   = '0;

    // Reset state
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    read_z(rd);
    check("reset_z", rd, 8'h00);
    read_zh(rd);
    check("reset_zh", rd, 8'h00);
    check("reset_flags", bus.flags, 4'h0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    $display("[TB] reset: flags=%h busy=%b", bus.flags, bus.busy);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.CS_bus = vecs[i].cs;
      bus.acc    = vecs[i].a;
      bus.ibus   = vecs[i].b;
      sb.push_back('{vecs[i].z, vecs[i].fl});
      @(posedge clk);
      #1;
      read_z(rd);
      e = sb.pop_front();
      $display("[TB] vec %0d cs=%h a=%h b=%h -> z=%h flags=%h", i, vecs[i].cs, vecs[i].a, vecs[i].b,
               rd, bus.flags);
      check($sformatf("vec%0d_z", i), rd, e.z);
      check($sformatf("vec%0d_flags", i), bus.flags, e.fl);
      check($sformatf("vec%0d_busy", i), bus.busy, 1'b0);
    end

`ifdef ALU_SEQ_MUL_EN
    // 0xFF * 0xFF with an ADD attempt while busy
    @(negedge clk);
    bus.CS_bus = C_MUL;
    bus.acc    = 8'hFF;
    bus.ibus   = 8'hFF;
    @(posedge clk);
    #1 bus.CS_bus = '0;
    bus.acc  = 8'h01;
    bus.ibus = 8'h01;
    n  = 0;
    dn = 0;
    while (bus.busy && n < 20) begin
      n++;
      if (bus.done) dn++;
      if (n == 3) bus.CS_bus = C_ADD;
      if (n == 4) bus.CS_bus = '0;
      @(posedge clk);
      #1;
    end
    bus.CS_bus = '0;
    $display("[TB] mul ff*ff: busy cycles=%0d done=%b", n, bus.done);
    check("mul_busy_cycles", n, 8);
    check("mul_done_during_busy", dn, 0);
    check("mul_done_pulse", bus.done, 1'b1);
    check("mul_flags", bus.flags, 4'h2);
    bus.CS_bus = C_Z | C_ZH;
    #1 check("mul_z_priority", bus.obus, 8'h01);
    read_zh(rd);
    check("mul_zh", rd, 8'hFE);
    @(posedge clk);
    #1 check("mul_done_one_cycle", bus.done, 1'b0);
    read_z(rd);
    check("mul_z_after", rd, 8'h01);

    // Reset during RUN aborts the multiply
    @(negedge clk);
    bus.CS_bus = C_MUL;
    bus.acc    = 8'h03;
    bus.ibus   = 8'h05;
    @(posedge clk);
    #1 bus.CS_bus = '0;
    check("abort_busy_start", bus.busy, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) dn++;
      @(posedge clk);
      #1;
    end
    $display("[TB] abort: done pulses=%0d flags=%h", dn, bus.flags);
    check("abort_no_done", dn, 0);
    check("abort_flags", bus.flags, 4'h0);
    read_z(rd);
    check("abort_z", rd, 8'h00);
    read_zh(rd);
    check("abort_zh", rd, 8'h00);
`else
    // Without the multiplier the MUL bit is a no-op
    @(negedge clk);
    bus.CS_bus = C_MUL;
    bus.acc    = 8'h03;
    bus.ibus   = 8'h05;
    @(posedge clk);
    #1;
    check("nomul_busy", bus.busy, 1'b0);
    check("nomul_done", bus.done, 1'b0);
    check("nomul_flags", bus.flags, 4'hB);
    read_z(rd);
    check("nomul_z", rd, 8'h00);
    read_zh(rd);
    check("nomul_zh", rd, 8'h00);
    $display("[TB] mul bit without multiplier: z=%h flags=%h", 8'h00, bus.flags);
`endif

    bus.CS_bus = '0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
